inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Instruction buffer between the fetch unit and the decode/rename stage.
- Decouples fetch bandwidth from decode stalls by buffering fetched {pc, inst} pairs in program order.
- Presents the oldest entry to decode as pc/inst/inst_valid.
- Discards all contents on a pipeline flush (branch mispredict / redirect).

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
ADDR_W, 3, log2(DEPTH); pointer width

Ports:
clk_i  input  1  clock, all state updates on rising edge
reset_i  input  1  asynchronous, active-high reset
flush_i  input  1  discard all entries this cycle
fetch_valid_i  input  1  fetch presents a valid instruction
fetch_pc_i  input  32  PC of fetched instruction
fetch_inst_i  input  32  fetched instruction word
fetch_ready_o  output  1  queue can accept an entry this cycle
decode_ready_i  input  1  decode consumes head entry this cycle
inst_valid_o  output  1  head entry valid
pc_o  output  32  PC of head entry
inst_o  output  32  instruction word of head entry
count_o  output  ADDR_W+1  current occupancy, 0..DEPTH
full_o  output  1  count_o == DEPTH
empty_o  output  1  count_o == 0

Behaviour:
- Reset (asynchronous, immediate on reset_i high, including mid-operation):
  - head/tail pointers = 0, count = 0.
  - inst_valid_o = 0, pc_o = 0, inst_o = 0.
  - fetch_ready_o = 1, full_o = 0, empty_o = 1.
  - Storage array is not reset; outputs are masked while empty.
- Push: push = fetch_valid_i & fetch_ready_o & !flush_i.
  - Writes {fetch_pc_i, fetch_inst_i} at tail; tail increments modulo DEPTH.
- Pop: pop = inst_valid_o & decode_ready_i & !flush_i.
  - Head increments modulo DEPTH.
- Readiness and head outputs:
  - fetch_ready_o = !full_o, combinational from registered count.
  - No bypass; a full queue never accepts an entry, even if a pop occurs the same cycle.
  - inst_valid_o = !empty_o.
  - pc_o / inst_o = entry at head when valid, else 0.
  - Head outputs are combinational reads of registered storage; no added latency.
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1. There is no same-cycle write-through when empty.
- Count update:
  - push & pop: count unchanged.
  - push only: +1.
  - pop only: -1.
  - Count never exceeds DEPTH or goes below 0.
- Flush (synchronous, highest priority after reset):
  - Next cycle: count = 0, head = tail = 0.
  - Any push or pop requested in the same cycle is dropped.
  - Outputs keep their pre-flush values during the flush cycle; inst_valid_o = 0 from the next cycle.
- Ordering: strict FIFO; entries leave in exactly the order they were accepted.
- Pointer wrap: after entry DEPTH-1, the next write/read goes to entry 0; full and empty are distinguished by count, not by pointers.
- decode_ready_i while empty has no effect. fetch_valid_i while full has no effect; fetch must hold its data until accepted.
- Invariants (assert in bench):
  - count_o == (tail - head) mod DEPTH, or DEPTH when full.
  - full_o and empty_o never both high.

Test Plan:
- Reset then idle:
  - inst_valid_o=0, pc_o=0, inst_o=0, count_o=0, empty_o=1, fetch_ready_o=1.
- Single entry:
  - Push pc=0x100, inst=0x00500093 with decode_ready_i=0.
  - Next cycle: inst_valid_o=1, pc_o=0x100, inst_o=0x00500093, count_o=1.
  - Assert decode_ready_i: next cycle empty_o=1.
- Fill and order:
  - Push 8 entries, pc=0x100+4k, with decode_ready_i=0.
  - full_o=1, fetch_ready_o=0; a 9th push is ignored.
  - Drain: pc_o sequence is 0x100..0x11C, then empty_o=1.
- Wrap with simultaneous push/pop:
  - Hold count at 3 with push+pop every cycle for 20 cycles.
  - count_o stays 3; popped PCs are consecutive across pointer wrap.
- Flush mid-stream:
  - With count=5, assert flush_i together with push and pop.
  - Next cycle: count_o=0, inst_valid_o=0; the pushed entry never appears.
  - The following push is visible one cycle later.
- Async reset mid-operation:
  - Assert reset_i between clock edges with count=4.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the queue behaves as empty.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode/rename.
// Buffers {pc, inst} pairs in program order; flush discards all entries.
module inst_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              fetch_valid_i,
  input  logic [31:0]       fetch_pc_i,
  input  logic [31:0]       fetch_inst_i,
  output logic              fetch_ready_o,
  input  logic              decode_ready_i,
  output logic              inst_valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  iq_entry_t         mem [DEPTH];
  iq_entry_t         head_entry;
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [ADDR_W:0]   count_q;
  logic              push;
  logic              pop;

  assign full_o        = (count_q == FULL_CNT);
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign fetch_ready_o = !full_o;
  assign inst_valid_o  = !empty_o;

  // Readiness comes from registered count only, so a full queue
  // refuses a push even when decode drains it the same cycle.
  assign push = fetch_valid_i & fetch_ready_o & !flush_i;
  assign pop  = inst_valid_o & decode_ready_i & !flush_i;

  assign head_entry = mem[head_q];
  assign pc_o       = inst_valid_o ? head_entry.pc   : '0;
  assign inst_o     = inst_valid_o ? head_entry.inst : '0;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[tail_q] <= '{pc: fetch_pc_i, inst: fetch_inst_i};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + 1'b1;
      end
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue.
// Reference model is a plain queue of {pc, inst} pairs.
module tb_inst_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk_i = 0;
  logic              reset_i;
  logic              flush_i;
  logic              fetch_valid_i;
  logic [31:0]       fetch_pc_i;
  logic [31:0]       fetch_inst_i;
  logic              fetch_ready_o;
  logic              decode_ready_i;
  logic              inst_valid_o;
  logic [31:0]       pc_o;
  logic [31:0]       inst_o;
  logic [ADDR_W:0]   count_o;
  logic              full_o;
  logic              empty_o;

  int checks = 0;
  int passes = 0;

  logic [63:0] q [$];

  inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i),
    .fetch_inst_i(fetch_inst_i), .fetch_ready_o(fetch_ready_o),
    .decode_ready_i(decode_ready_i), .inst_valid_o(inst_valid_o),
    .pc_o(pc_o), .inst_o(inst_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] exp_pc();
    return q.size() > 0 ? q[0][63:32] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_inst();
    return q.size() > 0 ? q[0][31:0] : 32'h0;
  endfunction

  // One clock: drive inputs, advance the model at the edge, return at negedge.
  task automatic step(input bit fv, input logic [31:0] pc,
                      input logic [31:0] ins, input bit dr, input bit fl);
    bit push, pop;
    fetch_valid_i  = fv;
    fetch_pc_i     = pc;
    fetch_inst_i   = ins;
    decode_ready_i = dr;
    flush_i        = fl;
    push = fv && (q.size() < DEPTH) && !fl;
    pop  = (q.size() > 0) && dr && !fl;
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({pc, ins});
    end
    @(negedge clk_i);
    fetch_valid_i  = 0;
    decode_ready_i = 0;
    flush_i        = 0;
  endtask

  task automatic test_reset();
    reset_i = 1;
    flush_i = 0;
    fetch_valid_i = 0;
    fetch_pc_i = 0;
    fetch_inst_i = 0;
    decode_ready_i = 0;
    repeat (2) @(negedge clk_i);
    reset_i = 0;
    q.delete();
    @(negedge clk_i);
    checks++;
    if ({inst_valid_o, pc_o, inst_o} !== 65'h0)
      $display("FAIL reset_head got v=%0b pc=%h inst=%h want 0/0/0",
               inst_valid_o, pc_o, inst_o);
    else passes++;
    checks++;
    if ({count_o, empty_o, full_o, fetch_ready_o} !== {4'd0, 3'b101})
      $display("FAIL reset_flags got cnt=%0d e=%0b f=%0b r=%0b want 0 1 0 1",
               count_o, empty_o, full_o, fetch_ready_o);
    else passes++;
  endtask

  task automatic test_single();
    step(1, 32'h100, 32'h00500093, 0, 0);
    checks++;
    if ({inst_valid_o, pc_o, inst_o, count_o} !==
        {1'b1, 32'h100, 32'h00500093, 4'd1})
      $display("FAIL single_head got v=%0b pc=%h inst=%h cnt=%0d want 1 100 00500093 1",
               inst_valid_o, pc_o, inst_o, count_o);
    else passes++;
    step(0, 0, 0, 1, 0);
    checks++;
    if ({empty_o, inst_valid_o, pc_o} !== {2'b10, 32'h0})
      $display("FAIL single_pop got e=%0b v=%0b pc=%h want 1 0 0",
               empty_o, inst_valid_o, pc_o);
    else passes++;
  endtask

  task automatic test_fill_order();
    for (int k = 0; k < DEPTH; k++)
      step(1, 32'h100 + 4 * k, $urandom, 0, 0);
    checks++;
    if ({full_o, fetch_ready_o, count_o} !== {2'b10, 4'd8})
      $display("FAIL fill_full got f=%0b r=%0b cnt=%0d want 1 0 8",
               full_o, fetch_ready_o, count_o);
    else passes++;
    step(1, 32'hDEAD, 32'hBEEF, 0, 0);
    checks++;
    if (count_o !== 4'd8 || pc_o !== 32'h100)
      $display("FAIL fill_ninth got cnt=%0d pc=%h want 8 100", count_o, pc_o);
    else passes++;
    // No bypass: push while full with a pop must not be accepted.
    step(1, 32'hDEAD, 32'hBEEF, 1, 0);
    checks++;
    if (count_o !== 4'd7 || pc_o !== 32'h104)
      $display("FAIL fill_nobypass got cnt=%0d pc=%h want 7 104", count_o, pc_o);
    else passes++;
    for (int k = 1; k < DEPTH; k++) begin
      checks++;
      if (pc_o !== 32'h100 + 4 * k || inst_o !== exp_inst())
        $display("FAIL drain_order k=%0d got pc=%h inst=%h want %h %h",
                 k, pc_o, inst_o, 32'h100 + 4 * k, exp_inst());
      else passes++;
      step(0, 0, 0, 1, 0);
    end
    checks++;
    if (empty_o !== 1'b1 || count_o !== 4'd0)
      $display("FAIL drain_empty got e=%0b cnt=%0d want 1 0", empty_o, count_o);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc;
    logic [31:0] want;
    next_pc = 32'h2000;
    want = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      step(1, next_pc, $urandom, 0, 0);
      next_pc += 4;
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (pc_o !== want || count_o !== 4'd3)
        $display("FAIL wrap_pop k=%0d got pc=%h cnt=%0d want %h 3",
                 k, pc_o, count_o, want);
      else passes++;
      step(1, next_pc, $urandom, 1, 0);
      next_pc += 4;
      want += 4;
    end
    while (q.size() > 0) step(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush();
    logic [31:0] pre_pc;
    for (int k = 0; k < 5; k++)
      step(1, 32'h3000 + 4 * k, $urandom, 0, 0);
    pre_pc = pc_o;
    fetch_valid_i  = 1;
    fetch_pc_i     = 32'h9999;
    decode_ready_i = 1;
    flush_i        = 1;
    #1;
    checks++;
    if (pc_o !== 32'h3000 || count_o !== 4'd5)
      $display("FAIL flush_hold got pc=%h cnt=%0d want 3000 5", pc_o, count_o);
    else passes++;
    step(1, 32'h9999, 32'h1, 1, 1);
    checks++;
    if ({count_o, inst_valid_o, pc_o} !== {4'd0, 1'b0, 32'h0})
      $display("FAIL flush_clear got cnt=%0d v=%0b pc=%h want 0 0 0",
               count_o, inst_valid_o, pc_o);
    else passes++;
    step(1, 32'h4000, 32'h00A00113, 0, 0);
    checks++;
    if ({inst_valid_o, pc_o, inst_o, count_o} !==
        {1'b1, 32'h4000, 32'h00A00113, 4'd1})
      $display("FAIL flush_after got v=%0b pc=%h inst=%h cnt=%0d want 1 4000 00a00113 1",
               inst_valid_o, pc_o, inst_o, count_o);
    else passes++;
    if (pre_pc == 32'h9999) $display("FAIL flush_prepc got 9999 want other");
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++)
      step(1, 32'h5000 + 4 * k, $urandom, 0, 0);
    checks++;
    if (count_o !== 4'd4)
      $display("FAIL areset_pre got cnt=%0d want 4", count_o);
    else passes++;
    #2 reset_i = 1;
    #1;
    checks++;
    if ({inst_valid_o, pc_o, inst_o, count_o, empty_o, full_o, fetch_ready_o}
        !== {1'b0, 64'h0, 4'd0, 3'b101})
      $display("FAIL areset_now got v=%0b pc=%h inst=%h cnt=%0d e=%0b f=%0b r=%0b",
               inst_valid_o, pc_o, inst_o, count_o, empty_o, full_o, fetch_ready_o);
    else passes++;
    @(negedge clk_i);
    reset_i = 0;
    q.delete();
    step(1, 32'h6000, 32'h13, 0, 0);
    checks++;
    if (count_o !== 4'd1 || pc_o !== 32'h6000)
      $display("FAIL areset_after got cnt=%0d pc=%h want 1 6000", count_o, pc_o);
    else passes++;
    step(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h8000;
    for (int n = 0; n < 400; n++) begin
      bit fv, dr, fl;
      fv = ($urandom_range(0, 99) < 60);
      dr = ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      step(fv, pc, $urandom, dr, fl);
      if (fv && !fl) pc += 4;
      checks++;
      if (inst_valid_o !== (q.size() > 0) || pc_o !== exp_pc() ||
          inst_o !== exp_inst() || count_o !== q.size() ||
          full_o !== (q.size() == DEPTH) || empty_o !== (q.size() == 0) ||
          fetch_ready_o !== (q.size() < DEPTH) || (full_o && empty_o))
        $display("FAIL random n=%0d got v=%0b pc=%h inst=%h cnt=%0d f=%0b e=%0b want cnt=%0d pc=%h inst=%h",
                 n, inst_valid_o, pc_o, inst_o, count_o, full_o, empty_o,
                 q.size(), exp_pc(), exp_inst());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
